// File: rtl/axi_mem_if.sv
// Reduced AXI-4 bus between the SLZW codec master and a memory slave:
// no IDs, no response codes, no RLAST.
interface axi_mem_if;
  // Each channel transfers on a rising clk edge where valid and ready are both
  // high; the source holds valid and payload stable until that edge.
  logic [31:0] axm_awaddr;
  logic [7:0]  axm_awlen;
  logic [2:0]  axm_awprot;
  logic        axm_awvalid;
  logic        axm_awready;
  logic [31:0] axm_wdata;
  logic        axm_wlast;
  logic        axm_wvalid;
  logic        axm_wready;
  logic        axm_bvalid;
  logic        axm_bready;
  logic [31:0] axm_araddr;
  logic [7:0]  axm_arlen;
  logic [3:0]  axm_arcache;
  logic        axm_aruser;
  logic [2:0]  axm_arprot;
  logic        axm_arvalid;
  logic        axm_arready;
  logic [31:0] axm_rdata;
  logic        axm_rvalid;
  logic        axm_rready;

  modport master (
    output axm_awaddr, axm_awlen, axm_awprot, axm_awvalid,
    input  axm_awready,
    output axm_wdata, axm_wlast, axm_wvalid,
    input  axm_wready,
    input  axm_bvalid,
    output axm_bready,
    output axm_araddr, axm_arlen, axm_arcache, axm_aruser, axm_arprot, axm_arvalid,
    input  axm_arready,
    input  axm_rdata, axm_rvalid,
    output axm_rready
  );

  modport slave (
    input  axm_awaddr, axm_awlen, axm_awprot, axm_awvalid,
    output axm_awready,
    input  axm_wdata, axm_wlast, axm_wvalid,
    output axm_wready,
    output axm_bvalid,
    input  axm_bready,
    input  axm_araddr, axm_arlen, axm_arcache, axm_aruser, axm_arprot, axm_arvalid,
    output axm_arready,
    output axm_rdata, axm_rvalid,
    input  axm_rready
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI-4 slave backed by a word-wide on-chip RAM, one INCR burst at a time.
// Define AXI_MEM_RESPONDER_STALL_EN to add LFSR-driven backpressure on W, B and R.
module axi_mem_responder #(
  parameter int          MEM_ADDR_BITS = 12,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       reset_n,
  axi_mem_if.slave   axm,
  output logic       busy,
  output logic       wlast_err,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WRESP = 2'd2,
    RDATA = 2'd3
  } state_t;

  localparam logic [MEM_ADDR_BITS-1:0] IDX_ONE = 1;

  state_t                   state;
  logic                     rr_read;
  logic [MEM_ADDR_BITS-1:0] idx;
  logic [MEM_ADDR_BITS-1:0] rd_addr;
  logic [7:0]               len;
  logic [7:0]               beat;
  logic                     wready_q;
  logic                     bvalid_q;
  logic                     rvalid_q;
  logic [31:0]              rdata_q;
  logic [31:0]              mem [2**MEM_ADDR_BITS];

  logic [31:0] aw_off;
  logic [31:0] ar_off;
  logic        grant_w;
  logic        grant_r;
  logic        aw_hs;
  logic        ar_hs;
  logic        w_hs;
  logic        r_hs;
  logic        last_beat;
  logic        stall_w;
  logic        stall_r;
  logic        stall_b;

`ifdef AXI_MEM_RESPONDER_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall_w = lfsr[0];
  assign stall_r = lfsr[1];
  assign stall_b = lfsr[2];
`else
  assign stall_w = 1'b0;
  assign stall_r = 1'b0;
  assign stall_b = 1'b0;
`endif

  assign aw_off = axm.axm_awaddr - BASE_ADDR;
  assign ar_off = axm.axm_araddr - BASE_ADDR;

  // rr_read breaks ties only when both address channels request together.
  assign grant_w = axm.axm_awvalid & (~axm.axm_arvalid | ~rr_read);
  assign grant_r = axm.axm_arvalid & (~axm.axm_awvalid | rr_read);

  assign axm.axm_awready = (state == IDLE) & grant_w;
  assign axm.axm_arready = (state == IDLE) & grant_r;
  assign axm.axm_wready  = wready_q & ~stall_w;
  assign axm.axm_bvalid  = bvalid_q;
  assign axm.axm_rvalid  = rvalid_q;
  assign axm.axm_rdata   = rdata_q;

  assign aw_hs     = axm.axm_awvalid & axm.axm_awready;
  assign ar_hs     = axm.axm_arvalid & axm.axm_arready;
  assign w_hs      = axm.axm_wvalid & axm.axm_wready;
  assign r_hs      = rvalid_q & axm.axm_rready;
  assign last_beat = (beat == len);

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // Look one word ahead on a consumed beat so the registered RAM output
  // already carries the next beat on the following cycle.
  always_comb begin
    rd_addr = idx;
    if (state == IDLE) begin
      rd_addr = ar_off[MEM_ADDR_BITS+1:2];
    end else if (state == RDATA && r_hs) begin
      rd_addr = idx + IDX_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && w_hs) begin
      mem[idx] <= axm.axm_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_read   <= 1'b0;
      idx       <= '0;
      len       <= 8'd0;
      beat      <= 8'd0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      wlast_err <= 1'b0;
    end else begin
      if (ar_hs || r_hs) begin
        rdata_q <= mem[rd_addr];
      end
      case (state)
        IDLE: begin
          if (aw_hs) begin
            idx      <= aw_off[MEM_ADDR_BITS+1:2];
            len      <= axm.axm_awlen;
            beat     <= 8'd0;
            wready_q <= 1'b1;
            rr_read  <= ~rr_read;
            state    <= WDATA;
          end else if (ar_hs) begin
            idx      <= ar_off[MEM_ADDR_BITS+1:2];
            len      <= axm.axm_arlen;
            beat     <= 8'd0;
            rvalid_q <= ~stall_r;
            rr_read  <= ~rr_read;
            state    <= RDATA;
          end
        end
        WDATA: begin
          if (w_hs) begin
            idx  <= idx + IDX_ONE;
            beat <= beat + 8'd1;
            // The beat count, not wlast, ends the burst; wlast is only audited.
            if (axm.axm_wlast != last_beat) begin
              wlast_err <= 1'b1;
            end
            if (last_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= ~stall_b;
              state    <= WRESP;
            end
          end
        end
        WRESP: begin
          if (bvalid_q && axm.axm_bready) begin
            bvalid_q <= 1'b0;
            state    <= IDLE;
          end else if (!bvalid_q) begin
            bvalid_q <= ~stall_b;
          end
        end
        RDATA: begin
          if (r_hs) begin
            if (last_beat) begin
              rvalid_q <= 1'b0;
              state    <= IDLE;
            end else begin
              idx      <= rd_addr;
              beat     <= beat + 8'd1;
              rvalid_q <= ~stall_r;
            end
          end else if (!rvalid_q) begin
            rvalid_q <= ~stall_r;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{aw_off[1:0], aw_off[31:MEM_ADDR_BITS+2],
                         ar_off[1:0], ar_off[31:MEM_ADDR_BITS+2],
                         axm.axm_awprot, axm.axm_arcache, axm.axm_aruser,
                         axm.axm_arprot};

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI-4 slave memory responder that terminates the reduced AXI-4 master bus driven by the SLZW codec: write address/data/response and read address/data channels, with no IDs, no RRESP/BRESP and no RLAST. It backs the bus with a word-wide on-chip RAM. The block is instantiated in the simulation bench in place of the HPS SDRAM path, and in `core` when the codec is built for a standalone on-chip-memory variant. Accepts INCR bursts one transaction at a time, with full-throughput data beats.

## Interface
Parameters:
- MEM_ADDR_BITS, 12, log2 of RAM depth in 32-bit words (4096 words).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; it is subtracted before indexing.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- axm_awaddr  in  32  write burst start byte address.
- axm_awlen  in  8  write beats minus 1.
- axm_awprot  in  3  ignored.
- axm_awvalid / axm_awready  in / out  1  write address handshake.
- axm_wdata  in  32  write data.
- axm_wlast  in  1  last write beat marker.
- axm_wvalid / axm_wready  in / out  1  write data handshake.
- axm_bvalid / axm_bready  out / in  1  write response handshake (OKAY is implied).
- axm_araddr  in  32  read burst start byte address.
- axm_arlen  in  8  read beats minus 1.
- axm_arcache, axm_aruser, axm_arprot  in  4, 1, 3  ignored.
- axm_arvalid / axm_arready  in / out  1  read address handshake.
- axm_rdata  out  32  read data.
- axm_rvalid / axm_rready  out / in  1  read data handshake.
- busy  out  1  high whenever the FSM is not in IDLE.
- wlast_err  out  1  sticky flag for a wlast/awlen mismatch; cleared only by reset.

## Operation
- FSM states are IDLE, WDATA, WRESP and RDATA. One transaction is in flight at a time.
- **IDLE:**
  - axm_awready = axm_arvalid-independent priority winner for writes; axm_arready likewise for reads. Both readies are asserted combinationally only in IDLE, and only for the arbitration winner.
  - Arbitration: if only one of awvalid/arvalid is high, that request wins. If both are high, a round-robin bit decides; it resets to "write first" and toggles after each granted transaction.
  - On an AW handshake: latch the word index and awlen, clear the beat count, and go to WDATA.
  - On an AR handshake: same latching for the read, then go to RDATA.
- **Word index:** (addr − BASE_ADDR)[MEM_ADDR_BITS+1:2]. Byte bits [1:0] are ignored.
  - The index increments by 1 per beat and wraps modulo 2^MEM_ADDR_BITS.
  - Bursts are always INCR.
- **WDATA:**
  - axm_wready = 1.
  - Each wvalid&wready writes wdata to mem[index], then increments the index and the beat count.
  - The burst ends on the beat where beat count == awlen, and the FSM goes to WRESP. wlast is not used to terminate.
  - wlast_err is set if wlast=1 on any earlier beat, or if wlast=0 on the final beat.
- **WRESP:** axm_bvalid = 1 until bready is sampled high, then go to IDLE.
- **RDATA:**
  - The RAM read address is combinational: in IDLE it is the araddr index; in RDATA it is index+1 on an rvalid&rready beat, otherwise index.
  - The RAM output is registered and drives axm_rdata.
  - axm_rvalid is high throughout RDATA. rdata and rvalid hold stable while rready=0.
  - After the handshake with beat count == arlen, go to IDLE.
- Memory contents are not reset.

## Timing
- Reset values: axm_awready=0, axm_wready=0, axm_bvalid=0, axm_arready=0, axm_rvalid=0, axm_rdata=0, busy=0, wlast_err=0, state=IDLE, round-robin bit = write.
- AW handshake at cycle N: wready=1 from N+1. The first write lands in RAM at the edge of the beat handshake.
- Final W beat at cycle M: bvalid=1 at M+1.
- bready handshake at cycle K: IDLE at K+1, so a new AW/AR can be accepted at K+1.
- AR handshake at cycle N: rvalid=1 with beat-0 data at N+1. Subsequent beats follow every cycle while rready=1.
- Last R handshake at cycle K: rvalid=0 and IDLE at K+1.
- Reset asserted mid-burst: the next cycle is IDLE with all outputs at reset values. The burst is abandoned with no bvalid; RAM writes already done are kept.
- awlen=0 / arlen=0: single-beat transfer.
- A burst crossing the top of the RAM wraps to word 0.

## Configuration
- AXI_MEM_RESPONDER_STALL_EN
  - Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
    - In WDATA, wready is forced to 0 while lfsr[0]=1.
    - In RDATA, rvalid is not raised for a new beat while lfsr[1]=1.
    - Once raised, rvalid holds until the handshake (AXI rule).
    - bvalid assertion is delayed while lfsr[2]=1.
  - Undefined: no LFSR; the timing is exactly as above.

## Test plan
- Single write then read: AW 0x40, awlen=0, wdata=0xDEADBEEF, bready=1, then AR 0x40, arlen=0 → bvalid one cycle after the beat; rvalid one cycle after AR with rdata=0xDEADBEEF.
- 4-beat burst: write 0x100..0x10C with data 1,2,3,4, then read back with rready=1 → four consecutive rvalid cycles carrying 1,2,3,4. Repeat with rready toggling every cycle → rdata holds during each stall.
- Wrap: AW at word 4095 with awlen=1 and data 0xA,0xB → mem[4095]=0xA and mem[0]=0xB, verified via read bursts at 0x3FFC and 0x0.
- Simultaneous awvalid and arvalid from reset → write is granted first. The next simultaneous pair → read is granted first.
- wlast early: awlen=3 with wlast on beat 1 → wlast_err=1, the burst still takes 4 beats, bvalid is issued, and wlast_err stays 1 until reset.
- Reset mid-read at beat 2 of arlen=7 → the next cycle has rvalid=0, busy=0, and arready available to a new request.
